rf_writeback: RTL and testbench

Write-side front end of the integer register file. It collects results from the ALU channel, which goes through a DEPTH-entry FIFO, and from the load channel, which is unbuffered. It arbitrates them round-robin onto the register file's single write port (rd / DataWr / RFWr) and keeps a pending-write scoreboard that the issue stage uses to stall on RAW hazards.

---
 rtl/rf_wb_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 63 ++++++
 rtl/rf_writeback.sv | 121 ++++++++++++
 tb/tb_rf_writeback.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// Shared types and widths for the register-file write-back front end.
package rf_wb_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NREGS  = 32;

    // One pending register-file write: destination index plus data.
    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // Which channel received the most recent grant.
    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_LD  = 1'b1
    } grant_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back requests. The head entry is readable
// combinationally so the arbiter can grant it in the same cycle it appears.
// DEPTH must be a power of two (at least 2) so the pointers wrap naturally.
module wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     push_i,
    input  wb_req_t                  push_req_i,
    input  logic                     pop_i,
    output wb_req_t                  head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_req_t            mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               push_ok;
    logic               pop_ok;

    // Guard against overflow/underflow so a misbehaving caller cannot corrupt state.
    assign push_ok = push_i && (count_q != CNT_W'(DEPTH));
    assign pop_ok  = pop_i  && (count_q != '0);

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage is not reset: resetting the pointers is enough to discard contents.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_req_i;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop keep count.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rf_writeback.sv
// Write-side front end of the integer register file: buffers ALU results,
// arbitrates them round-robin against unbuffered loads onto the single write
// port, and tracks outstanding destinations for RAW-hazard stalls.
module rf_writeback
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    iss_valid,
    input  logic [ADDR_W-1:0]       iss_rd,
    output logic [NREGS-1:0]        busy,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [ADDR_W-1:0]       alu_rd,
    input  logic [DATA_W-1:0]       alu_data,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic [ADDR_W-1:0]       ld_rd,
    input  logic [DATA_W-1:0]       ld_data,
    output logic [ADDR_W-1:0]       rd,
    output logic [DATA_W-1:0]       DataWr,
    output logic                    RFWr,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_req_t             fifo_head;
    wb_req_t             alu_req;
    wb_req_t             sel_req;
    logic                fifo_nempty;
    logic                fifo_full;
    logic                alu_push;
    logic                gnt_alu;
    logic                gnt_ld;
    grant_e              last_grant_q;
    logic [ADDR_W-1:0]   rd_q;
    logic [DATA_W-1:0]   data_q;
    logic                rfwr_q;
    logic [NREGS-1:0]    busy_q;
    logic [NREGS-1:0]    busy_d;

    assign alu_req.rd   = alu_rd;
    assign alu_req.data = alu_data;

    assign fifo_nempty = (count != '0);
    assign fifo_full   = (count == CNT_W'(DEPTH));

    // Readiness depends only on state; both handshakes are held off during reset.
    assign alu_ready = RST_N && !fifo_full;
    assign alu_push  = alu_valid && alu_ready;

    // Round-robin: the FIFO head wins alone, or on a tie when the load had the last grant.
    assign gnt_alu  = fifo_nempty && (!ld_valid || (last_grant_q == GNT_LD));
    assign gnt_ld   = RST_N && ld_valid && !gnt_alu;
    assign ld_ready = gnt_ld;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .push_i     (alu_push),
        .push_req_i (alu_req),
        .pop_i      (gnt_alu),
        .head_o     (fifo_head),
        .count_o    (count)
    );

    // Select the payload of whichever channel holds the grant.
    always_comb begin
        sel_req = fifo_head;
        if (!gnt_alu) begin
            sel_req.rd   = ld_rd;
            sel_req.data = ld_data;
        end
    end

    // Write-port registers: load on a grant, x0 results are consumed without a write.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_q         <= '0;
            data_q       <= '0;
            rfwr_q       <= 1'b0;
            last_grant_q <= GNT_ALU;
        end else if (gnt_alu || gnt_ld) begin
            rd_q         <= sel_req.rd;
            data_q       <= sel_req.data;
            rfwr_q       <= (sel_req.rd != '0);
            last_grant_q <= gnt_alu ? GNT_ALU : GNT_LD;
        end else begin
            rfwr_q       <= 1'b0;
        end
    end

    // Per-register pending bit: a new allocation outranks a completing write.
    assign busy_d[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NREGS; gi++) begin : g_busy
            assign busy_d[gi] = (iss_valid && (iss_rd == ADDR_W'(gi)))
                              || (busy_q[gi] && !(rfwr_q && (rd_q == ADDR_W'(gi))));
        end
    endgenerate

    // Scoreboard register; reset drops every outstanding entry.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rd     = rd_q;
    assign DataWr = data_q;
    assign RFWr   = rfwr_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_rf_writeback.sv
// Self-checking bench for rf_writeback: a reference model of the FIFO and the
// round-robin arbiter feeds a write scoreboard, plus directed checks.
module tb_rf_writeback;
    import rf_wb_pkg::*;

    localparam int DEPTH = 4;

    logic                   CLK;
    logic                   RST_N;
    logic                   iss_valid;
    logic [ADDR_W-1:0]      iss_rd;
    logic [NREGS-1:0]       busy;
    logic                   alu_valid;
    logic                   alu_ready;
    logic [ADDR_W-1:0]      alu_rd;
    logic [DATA_W-1:0]      alu_data;
    logic                   ld_valid;
    logic                   ld_ready;
    logic [ADDR_W-1:0]      ld_rd;
    logic [DATA_W-1:0]      ld_data;
    logic [ADDR_W-1:0]      rd;
    logic [DATA_W-1:0]      DataWr;
    logic                   RFWr;
    logic [$clog2(DEPTH):0] count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    wb_req_t          m_fifo[$];
    wb_req_t          sb[$];
    logic             m_last_ld;
    logic             m_rfwr;
    logic [ADDR_W-1:0] m_rd;
    logic [NREGS-1:0] m_busy;
    logic             seen_full_pop;

    rf_writeback #(.DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .busy      (busy),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .rd        (rd),
        .DataWr    (DataWr),
        .RFWr      (RFWr),
        .count     (count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        sb.delete();
        m_last_ld = 1'b0;
        m_rfwr    = 1'b0;
        m_rd      = '0;
        m_busy    = '0;
    endtask

    task automatic offer_alu(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
        alu_valid = 1'b1;
        alu_rd    = r;
        alu_data  = d;
    endtask

    task automatic offer_ld(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
        ld_valid = 1'b1;
        ld_rd    = r;
        ld_data  = d;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] r);
        iss_valid = 1'b1;
        iss_rd    = r;
    endtask

    // One clock cycle: check handshakes before the edge, outputs after it.
    // Accepted offers and the issue strobe are withdrawn afterwards.
    task automatic cycle();
        bit ga, gl, ar, push;
        wb_req_t g;
        wb_req_t e;
        logic [NREGS-1:0] nb;
        @(negedge CLK);
        ga   = (m_fifo.size() != 0) && (!ld_valid || m_last_ld);
        gl   = ld_valid && !ga;
        ar   = (m_fifo.size() != DEPTH);
        push = alu_valid && ar;
        check("count", 64'(count), 64'(m_fifo.size()));
        check("alu_ready", 64'(alu_ready), 64'(ar));
        check("ld_ready", 64'(ld_ready), 64'(gl));
        if (m_fifo.size() == DEPTH && ga) begin
            seen_full_pop = 1'b1;
            check("full_pop_alu_ready", 64'(alu_ready), 64'(0));
        end
        nb = m_busy;
        if (m_rfwr) nb[m_rd] = 1'b0;
        if (iss_valid && iss_rd != '0) nb[iss_rd] = 1'b1;
        @(posedge CLK);
        #1;
        g.rd   = ld_rd;
        g.data = ld_data;
        if (ga) g = m_fifo.pop_front();
        if (push) begin
            e.rd   = alu_rd;
            e.data = alu_data;
            m_fifo.push_back(e);
        end
        if (ga || gl) begin
            m_last_ld = gl;
            m_rfwr    = (g.rd != '0);
            m_rd      = g.rd;
            if (g.rd != '0) sb.push_back(g);
        end else begin
            m_rfwr = 1'b0;
        end
        m_busy = nb;
        check("RFWr", 64'(RFWr), 64'(m_rfwr));
        check("busy", 64'(busy), 64'(m_busy));
        if (RFWr === 1'b1 && sb.size() != 0) begin
            e = sb.pop_front();
            check("wr_rd", 64'(rd), 64'(e.rd));
            check("wr_data", 64'(DataWr), 64'(e.data));
            $display("[%0t] write x%0d <= %08h", $time, rd, DataWr);
        end
        if (push) alu_valid = 1'b0;
        if (gl)   ld_valid  = 1'b0;
        iss_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_RFWr"}, 64'(RFWr), 64'(0));
        check({tag, "_count"}, 64'(count), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_rd"}, 64'(rd), 64'(0));
        check({tag, "_DataWr"}, 64'(DataWr), 64'(0));
        check({tag, "_alu_ready"}, 64'(alu_ready), 64'(0));
        check({tag, "_ld_ready"}, 64'(ld_ready), 64'(0));
    endtask

    task automatic alu_only_scenario(input string tag);
        issue(5'd5);
        offer_alu(5'd5, 32'hDEADBEEF);
        cycle();                                   // E0: accepted, busy[5] set
        check({tag, "_busy5_set"}, 64'(busy[5]), 64'(1));
        check({tag, "_E0_RFWr"}, 64'(RFWr), 64'(0));
        cycle();                                   // E1: write registers loaded
        check({tag, "_E1_RFWr"}, 64'(RFWr), 64'(1));
        check({tag, "_E1_rd"}, 64'(rd), 64'(5));
        check({tag, "_E1_data"}, 64'(DataWr), 64'(32'hDEADBEEF));
        check({tag, "_E1_busy5"}, 64'(busy[5]), 64'(1));
        cycle();                                   // E2: write lands, busy clears
        check({tag, "_E2_busy5"}, 64'(busy[5]), 64'(0));
        check({tag, "_E2_RFWr"}, 64'(RFWr), 64'(0));
    endtask

    initial begin
        int n;
        bit reached;
        RST_N = 1'b1;
        iss_valid = 1'b0; iss_rd = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
        seen_full_pop = 1'b0;
        model_reset();
        #2 RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_reset_state("reset");
        @(posedge CLK);
        #2 RST_N = 1'b1;

        // ALU only
        alu_only_scenario("alu_only");

        // Contention: FIFO holds x1, load x2 arrives -> load first, then alternate
        offer_alu(5'd1, 32'h11);
        cycle();
        offer_alu(5'd3, 32'h33);
        offer_ld(5'd2, 32'h22);
        cycle();
        check("cont_first_ld", 64'(rd), 64'(2));
        offer_ld(5'd4, 32'h44);
        cycle();
        check("cont_second_alu", 64'(rd), 64'(1));
        cycle();
        check("cont_third_ld", 64'(rd), 64'(4));
        cycle();
        check("cont_fourth_alu", 64'(rd), 64'(3));
        check("cont_fourth_RFWr", 64'(RFWr), 64'(1));
        cycle();

        // Full FIFO: both channels streaming, ALU gets half the slots
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (!alu_valid) offer_alu(5'(10 + (n % 8)), 32'hA000_0000 + 32'(n));
            if (!ld_valid)  offer_ld(5'(20 + (n % 8)), 32'hB000_0000 + 32'(n));
            n++;
            cycle();
        end
        check("full_pop_seen", 64'(seen_full_pop), 64'(1));
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        repeat (DEPTH + 2) cycle();
        check("drain_count", 64'(count), 64'(0));

        // x0 results are consumed without writing
        issue(5'd0);
        offer_alu(5'd0, 32'hFFFF_FFFF);
        offer_ld(5'd0, 32'hEEEE_EEEE);
        cycle();
        check("x0_ld_RFWr", 64'(RFWr), 64'(0));
        cycle();
        check("x0_alu_RFWr", 64'(RFWr), 64'(0));
        check("x0_count", 64'(count), 64'(0));
        cycle();
        check("x0_busy0", 64'(busy[0]), 64'(0));

        // Scoreboard race: re-issue x7 while its write is on the port
        issue(5'd7);
        offer_alu(5'd7, 32'h77);
        cycle();
        cycle();
        check("race_RFWr", 64'(RFWr), 64'(1));
        check("race_rd", 64'(rd), 64'(7));
        issue(5'd7);
        cycle();
        check("race_busy7", 64'(busy[7]), 64'(1));

        // Reset mid-operation once count=3 with a write in flight
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            if (!alu_valid) offer_alu(5'(10 + (n % 8)), 32'hC000_0000 + 32'(n));
            if (!ld_valid)  offer_ld(5'(20 + (n % 8)), 32'hD000_0000 + 32'(n));
            n++;
            cycle();
            reached = (m_fifo.size() == 3) && m_rfwr;
        end
        check("midreset_reached", 64'(reached), 64'(1));
        check("midreset_pre_count", 64'(count), 64'(3));
        check("midreset_pre_RFWr", 64'(RFWr), 64'(1));
        #2 RST_N = 1'b0;
        #1;
        check("midreset_RFWr", 64'(RFWr), 64'(0));
        check("midreset_count", 64'(count), 64'(0));
        check("midreset_busy", 64'(busy), 64'(0));
        check("midreset_alu_ready", 64'(alu_ready), 64'(0));
        check("midreset_ld_ready", 64'(ld_ready), 64'(0));
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        model_reset();
        @(posedge CLK);
        #2 RST_N = 1'b1;

        alu_only_scenario("post_reset");
        check("final_sb_empty", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
